// File: rtl/dtree_pkg.sv
// Shared decision-tree definitions: default datapath widths, accumulator sizing
// and a sign-extension helper used by control and node_evaluator.
package dtree_pkg;

  localparam int DEF_FEATURES          = 3;
  localparam int DEF_FEATURE_BIT_DEPTH = 8;
  localparam int DEF_COEFF_BIT_DEPTH   = 4;
  localparam int DEF_BIAS_BIT_DEPTH    = 10;

  // Wide enough for bias plus FEATURES full-scale products, so no saturation is needed.
  function automatic int acc_w(input int features, input int feat_w,
                               input int coeff_w, input int bias_w);
    int prod_w;
    prod_w = feat_w + coeff_w;
    return ((bias_w > prod_w) ? bias_w : prod_w) + $clog2(features + 1);
  endfunction

  function automatic logic [63:0] sext(input logic [63:0] v, input int w);
    logic [63:0] r;
    r = '0;
    for (int i = 0; i < 64; i++) begin
      r[6'(i)] = (i < w) ? v[6'(i)] : v[6'(w - 1)];
    end
    return r;
  endfunction

endpackage

// File: rtl/node_evaluator_if.sv
// Link between the control stage / feature source and node_evaluator.
interface node_evaluator_if
  import dtree_pkg::*;
#(
  parameter int FEATURE_BIT_DEPTH = DEF_FEATURE_BIT_DEPTH,
  parameter int COEFF_BIT_DEPTH   = DEF_COEFF_BIT_DEPTH,
  parameter int BIAS_BIT_DEPTH    = DEF_BIAS_BIT_DEPTH
);
  // Feature words use valid/ready: a word transfers on a rising edge where both
  // feature_valid and feature_ready are 1; data must be stable while valid is held.
  logic                         feature_valid;
  logic [FEATURE_BIT_DEPTH-1:0] feature_data;
  logic                         feature_ready;
  logic                         tree_done;
  logic                         load_bias;
  logic                         add;
  logic                         mult;
  logic                         is_one;
  logic [COEFF_BIT_DEPTH-1:0]   coeff;
  logic [BIAS_BIT_DEPTH-1:0]    bias;
  logic                         next;
  logic                         child_direction;

  modport master (
    output feature_valid, feature_data, tree_done, load_bias, add, mult, is_one, coeff, bias,
    input  feature_ready, next, child_direction
  );

  modport slave (
    input  feature_valid, feature_data, tree_done, load_bias, add, mult, is_one, coeff, bias,
    output feature_ready, next, child_direction
  );

endinterface

// File: rtl/feature_buffer.sv
// Double-buffered feature store: shadow bank fills while the active bank is
// being traversed; banks swap when the shadow is full and the active is free.
module feature_buffer
  import dtree_pkg::*;
#(
  parameter int FEATURES          = DEF_FEATURES,
  parameter int FEATURE_BIT_DEPTH = DEF_FEATURE_BIT_DEPTH,
  localparam int IDX_W            = $clog2(FEATURES)
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         i_feature_valid,
  input  logic [FEATURE_BIT_DEPTH-1:0] i_feature_data,
  input  logic                         i_tree_done,
  input  logic [IDX_W-1:0]             i_rd_idx,
  output logic [FEATURE_BIT_DEPTH-1:0] o_rd_data,
  output logic                         o_feature_ready,
  output logic                         o_next
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES - 1);

  logic [FEATURE_BIT_DEPTH-1:0] r_active [FEATURES];
  logic [FEATURE_BIT_DEPTH-1:0] r_shadow [FEATURES];
  logic [IDX_W-1:0]             r_wr_ptr;
  logic                         r_active_full;
  logic                         r_shadow_full;
  logic                         r_live;
  logic                         w_wr_en;
  logic                         w_swap;

  // r_live keeps ready low until the first clock after reset release.
  assign o_feature_ready = r_live & ~r_shadow_full;
  assign o_next          = r_active_full;
  assign o_rd_data       = r_active[i_rd_idx];
  assign w_wr_en         = i_feature_valid & o_feature_ready;
  assign w_swap          = r_shadow_full & (i_tree_done | ~r_active_full);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < FEATURES; i++) begin
        r_active[i] <= '0;
        r_shadow[i] <= '0;
      end
      r_wr_ptr      <= '0;
      r_active_full <= 1'b0;
      r_shadow_full <= 1'b0;
      r_live        <= 1'b0;
    end else begin
      r_live <= 1'b1;
      if (w_wr_en) begin
        r_shadow[r_wr_ptr] <= i_feature_data;
        if (r_wr_ptr == LAST_IDX) begin
          r_wr_ptr      <= '0;
          r_shadow_full <= 1'b1;
        end else begin
          r_wr_ptr <= r_wr_ptr + 1'b1;
        end
      end
      // Write and swap are exclusive: writes need an empty shadow, swaps a full one.
      if (w_swap) begin
        r_active      <= r_shadow;
        r_active_full <= 1'b1;
        r_shadow_full <= 1'b0;
      end else if (i_tree_done) begin
        r_active_full <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/node_evaluator.sv
// Serial dot-product per tree node: acc = bias + sum(term), one feature per add
// strobe; the accumulator sign is returned to control as child_direction.
module node_evaluator
  import dtree_pkg::*;
#(
  parameter int FEATURES          = DEF_FEATURES,
  parameter int FEATURE_BIT_DEPTH = DEF_FEATURE_BIT_DEPTH,
  parameter int COEFF_BIT_DEPTH   = DEF_COEFF_BIT_DEPTH,
  parameter int BIAS_BIT_DEPTH    = DEF_BIAS_BIT_DEPTH
) (
  input logic              clk,
  input logic              reset,
  node_evaluator_if.slave  bus
);

  localparam int ACC_W = acc_w(FEATURES, FEATURE_BIT_DEPTH, COEFF_BIT_DEPTH, BIAS_BIT_DEPTH);
  localparam int IDX_W = $clog2(FEATURES);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(FEATURES - 1);

  logic signed [ACC_W-1:0]      r_acc;
  logic [IDX_W-1:0]             r_feat_idx;
  logic [FEATURE_BIT_DEPTH-1:0] w_feat;
  logic signed [ACC_W-1:0]      w_feat_x;
  logic signed [ACC_W-1:0]      w_coeff_x;
  logic signed [ACC_W-1:0]      w_bias_x;
  logic signed [ACC_W-1:0]      w_term;

  feature_buffer #(
    .FEATURES          (FEATURES),
    .FEATURE_BIT_DEPTH (FEATURE_BIT_DEPTH)
  ) u_buf (
    .clk             (clk),
    .reset           (reset),
    .i_feature_valid (bus.feature_valid),
    .i_feature_data  (bus.feature_data),
    .i_tree_done     (bus.tree_done),
    .i_rd_idx        (r_feat_idx),
    .o_rd_data       (w_feat),
    .o_feature_ready (bus.feature_ready),
    .o_next          (bus.next)
  );

  assign w_feat_x  = ACC_W'(sext(64'(w_feat), FEATURE_BIT_DEPTH));
  assign w_coeff_x = ACC_W'(sext(64'(bus.coeff), COEFF_BIT_DEPTH));
  assign w_bias_x  = ACC_W'(sext(64'(bus.bias), BIAS_BIT_DEPTH));

  always_comb begin
    w_term = '0;
    if (bus.mult) begin
      w_term = w_feat_x * w_coeff_x;
    end else if (bus.is_one) begin
      w_term = w_feat_x;
    end
  end

  // load_bias consumes feature 0, so the index restarts at 1 for the next add.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_acc      <= '0;
      r_feat_idx <= '0;
    end else if (bus.add) begin
      if (bus.load_bias) begin
        r_acc      <= w_bias_x + w_term;
        r_feat_idx <= IDX_W'(1);
      end else begin
        r_acc      <= r_acc + w_term;
        r_feat_idx <= (r_feat_idx == LAST_IDX) ? '0 : r_feat_idx + 1'b1;
      end
    end
  end

  assign bus.child_direction = ~r_acc[ACC_W-1];

endmodule

// File: tb/tb_node_evaluator.sv
// Directed bench for node_evaluator: dot products, double buffering and reset.
module tb_node_evaluator;
  import dtree_pkg::*;

  localparam int F  = 3;
  localparam int FW = 8;
  localparam int CW = 4;
  localparam int BW = 10;

  logic clk = 1'b0;
  logic reset;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  node_evaluator_if #(.FEATURE_BIT_DEPTH(FW), .COEFF_BIT_DEPTH(CW), .BIAS_BIT_DEPTH(BW)) bus ();

  node_evaluator #(
    .FEATURES(F), .FEATURE_BIT_DEPTH(FW), .COEFF_BIT_DEPTH(CW), .BIAS_BIT_DEPTH(BW)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic send_vec(input logic signed [7:0] a, input logic signed [7:0] b,
                          input logic signed [7:0] c, input int n);
    logic [7:0] v [3];
    int w;
    v[0] = a; v[1] = b; v[2] = c;
    for (int i = 0; i < n; i++) begin
      w = 0;
      while (!bus.feature_ready && w < 20) begin
        tick();
        w++;
      end
      if (!bus.feature_ready) chk("ready_timeout", 32'(bus.feature_ready), 1);
      bus.feature_valid = 1'b1;
      bus.feature_data  = v[i];
      tick();
    end
    bus.feature_valid = 1'b0;
  endtask

  task automatic run_node(input int b, input int c0, input int c1, input int c2,
                          input logic [2:0] m, input logic [2:0] o);
    int c [3];
    c[0] = c0; c[1] = c1; c[2] = c2;
    for (int i = 0; i < 3; i++) begin
      bus.load_bias = (i == 0);
      bus.add       = 1'b1;
      bus.mult      = m[i];
      bus.is_one    = o[i];
      bus.coeff     = 4'(c[i]);
      bus.bias      = 10'(b);
      tick();
    end
    bus.load_bias = 1'b0;
    bus.add       = 1'b0;
    bus.mult      = 1'b0;
    bus.is_one    = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    bus.feature_valid = 1'b0; bus.feature_data = '0; bus.tree_done = 1'b0;
    bus.load_bias = 1'b0; bus.add = 1'b0; bus.mult = 1'b0; bus.is_one = 1'b0;
    bus.coeff = '0; bus.bias = '0;
    #2 reset = 1'b0;
    #1;
    chk("rst_acc", 32'(dut.r_acc), 0);
    chk("rst_child", 32'(bus.child_direction), 1);
    chk("rst_next", 32'(bus.next), 0);
    chk("rst_ready", 32'(bus.feature_ready), 0);
    tick(); tick();
    reset = 1'b1;
    chk("ready_at_release", 32'(bus.feature_ready), 0);
    tick();
    chk("ready_after_release", 32'(bus.feature_ready), 1);

    // Vector A into an empty buffer: next rises two cycles after the last word.
    send_vec(10, -4, 7, 3);
    chk("a_ready_full", 32'(bus.feature_ready), 0);
    chk("a_next_n1", 32'(bus.next), 0);
    tick();
    chk("a_next_n2", 32'(bus.next), 1);
    chk("a_ready_swap", 32'(bus.feature_ready), 1);

    run_node(-20, 2, 0, 0, 3'b011, 3'b100);
    chk("n1_acc", 32'(dut.r_acc), 7);
    chk("n1_child", 32'(bus.child_direction), 1);

    run_node(-30, -1, 3, 1, 3'b011, 3'b100);
    chk("n2_acc", 32'(dut.r_acc), -45);
    chk("n2_child", 32'(bus.child_direction), 0);
    tick();
    chk("n2_hold_acc", 32'(dut.r_acc), -45);
    chk("n2_hold_child", 32'(bus.child_direction), 0);

    run_node(5, 7, 7, 7, 3'b000, 3'b000);
    chk("zero_terms_acc", 32'(dut.r_acc), 5);

    // Vector B loads behind A; A keeps serving until tree_done.
    send_vec(-128, -128, -128, 3);
    chk("b_ready_full", 32'(bus.feature_ready), 0);
    chk("b_next_held", 32'(bus.next), 1);
    run_node(0, 1, 1, 1, 3'b111, 3'b000);
    chk("a_still_active", 32'(dut.r_acc), 13);
    bus.tree_done = 1'b1;
    tick();
    bus.tree_done = 1'b0;
    chk("b_swap_next", 32'(bus.next), 1);
    chk("b_swap_ready", 32'(bus.feature_ready), 1);
    run_node(-512, -8, -8, -8, 3'b111, 3'b000);
    chk("extreme_acc", 32'(dut.r_acc), 2560);
    chk("extreme_child", 32'(bus.child_direction), 1);

    // tree_done with an empty shadow drops next until a fresh vector arrives.
    bus.tree_done = 1'b1;
    tick();
    bus.tree_done = 1'b0;
    chk("empty_done_next", 32'(bus.next), 0);
    chk("empty_done_ready", 32'(bus.feature_ready), 1);
    send_vec(1, 2, 3, 3);
    chk("c_next_n1", 32'(bus.next), 0);
    tick();
    chk("c_next_n2", 32'(bus.next), 1);
    run_node(0, 0, 0, 0, 3'b000, 3'b111);
    chk("c_sum_acc", 32'(dut.r_acc), 6);

    // Reset mid-node with a half-loaded shadow.
    send_vec(9, 9, 0, 2);
    chk("half_ready", 32'(bus.feature_ready), 1);
    bus.load_bias = 1'b1; bus.add = 1'b1; bus.is_one = 1'b1; bus.bias = 10'(100);
    tick();
    chk("pre_rst_acc", 32'(dut.r_acc), 101);
    bus.load_bias = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("mid_rst_acc", 32'(dut.r_acc), 0);
    chk("mid_rst_child", 32'(bus.child_direction), 1);
    chk("mid_rst_next", 32'(bus.next), 0);
    chk("mid_rst_ready", 32'(bus.feature_ready), 0);
    chk("mid_rst_wr_ptr", 32'(dut.u_buf.r_wr_ptr), 0);
    bus.add = 1'b0; bus.is_one = 1'b0; bus.bias = '0;
    @(posedge clk);
    #1 reset = 1'b1;
    chk("rel_ready_0", 32'(bus.feature_ready), 0);
    tick();
    chk("rel_ready_1", 32'(bus.feature_ready), 1);
    chk("rel_next", 32'(bus.next), 0);

    send_vec(5, 6, 7, 3);
    tick();
    chk("e_next", 32'(bus.next), 1);
    run_node(0, 0, 0, 0, 3'b000, 3'b111);
    chk("e_sum_acc", 32'(dut.r_acc), 18);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/node_evaluator.md
# node_evaluator

Serial dot-product datapath that sits directly downstream of the decision-tree `control` stage and closes its loop. It buffers incoming spike feature vectors and, per tree node, evaluates bias + Σ coeff·feature one feature per cycle under `load_bias`/`add`/`mult`/`is_one` strobes. It returns the sign of the result to `control` as `child_direction`. It double-buffers features so the next vector loads while the current one is traversed.

## Interface
- `FEATURES`, 3, features per spike vector (≥2)
- `FEATURE_BIT_DEPTH`, 8, signed feature word width
- `COEFF_BIT_DEPTH`, 4, signed coefficient width
- `BIAS_BIT_DEPTH`, 10, signed bias width
- `clk`  input  1  single clock, all state on rising edge
- `reset`  input  1  asynchronous, active-low (0 = reset)
- `feature_valid`  input  1  feature word offered
- `feature_data`  input  FEATURE_BIT_DEPTH  signed feature word; vectors sent feature 0 first
- `feature_ready`  output  1  shadow buffer accepts a word
- `tree_done`  input  1  `control` `out_valid`; current vector finished
- `load_bias`, `add`, `mult`, `is_one`  input  1 each  strobes from `control`
- `coeff`  input  COEFF_BIT_DEPTH  signed coefficient for current feature
- `bias`  input  BIAS_BIT_DEPTH  signed node bias
- `next`  output  1  active buffer holds a complete vector
- `child_direction`  output  1  1 when accumulator ≥ 0, else 0

## Operation
- Term select, per `add` cycle, feature f = active[feat_idx]:
  - `mult`=1: term = coeff·f (signed).
  - `mult`=0, `is_one`=1: term = f.
  - `mult`=0, `is_one`=0: term = 0.
- Accumulator update:
  - `load_bias`=1 (with `add`=1): acc ← sext(bias) + term; feat_idx ← 1.
  - `add`=1, `load_bias`=0: acc ← acc + term; feat_idx ← feat_idx+1, wrapping FEATURES-1 → 0.
  - `add`=0: acc and feat_idx hold.
- Widths: ACC_W = max(BIAS_BIT_DEPTH, FEATURE_BIT_DEPTH+COEFF_BIT_DEPTH) + clog2(FEATURES+1). All operands are sign-extended to ACC_W. Overflow is impossible by construction; no saturation.
- `child_direction` = ~acc[ACC_W-1], combinational from the acc register.
- Feature buffering: two FEATURES-word banks, active and shadow, with a shadow write pointer and full flags.
  - A word is written when `feature_valid` & `feature_ready`.
  - `feature_ready` = ~shadow_full.
- Swap rule: if shadow_full at the cycle start and (`tree_done` or ~active_full), then active ← shadow, active_full ← 1, shadow empties.
  - Shadow completing in the same cycle does not swap; the swap waits for the next qualifying cycle.
- `tree_done` with shadow not full: active_full ← 0 and `next` drops until a swap.
- Active bank contents are never modified while active_full=1.

## Timing
- Reset values (asynchronous, `reset`=0):
  - acc=0, so `child_direction`=1.
  - feat_idx=0, banks empty.
  - `next`=0, `feature_ready`=0 while in reset, 1 from the first cycle after release.
- Latency: a term strobed in cycle n is in acc at n+1. After the FEATURES-th `add` cycle of a node, `child_direction` is valid in the following cycle, which is `control`'s DECIDE cycle. It holds until the next `load_bias`.
- Swap: `next` rises the cycle after the swap condition.
  - Minimum: last shadow word in cycle n gives `next`=1 at n+2 when active is empty.
- `feature_ready` falls the cycle after the FEATURES-th word is accepted. It rises the cycle after a swap.
- Strobes arriving while active_full=0 still update acc from stale bank data; the result is don't-care and `next`=0 flags it.
- Reset asserted mid-node or mid-load clears everything immediately. Partially loaded shadow words are discarded.

## Structure
- Shared package `dtree_pkg`: ACC_W function, signed-extension helper, default parameter values shared with `control`.
- Sub-module `feature_buffer`: owns the two banks, write pointer, full flags, swap logic, `feature_ready` and `next`. It exposes a FEATURES-wide read port indexed by feat_idx.
- Top level holds the term mux, accumulator and feat_idx.

## Test plan
- FEATURES=3, vector {10,-4,7}, bias=-20, coeffs {2,0,is_one}: acc = -20+20+0+7 = 7 → `child_direction`=1 in the cycle after the third `add`.
- Same vector, bias=-30, coeffs {-1,3,1(is_one)}: -30-10-12+7 = -45 → `child_direction`=0.
- Extreme values with FEATURE=-128, COEFF=-8 on all three features, bias=-512: acc = -512+3072 = 2560, no overflow → `child_direction`=1.
- Load vector A, then vector B while A is active: `feature_ready` drops after B's third word. `next` stays 1. On `tree_done`, the banks swap and the next node uses B's values.
- `tree_done` with an empty shadow → `next`=0 the following cycle. Loading a fresh vector raises `next` 2 cycles after its last word.
- Assert `reset` during the second `add` cycle of a node and during a half-loaded shadow → acc=0, `child_direction`=1, `next`=0 and the banks empty immediately. `feature_ready`=1 one cycle after release.
